// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares one single-port data memory between two requesters using a
//   round-robin arbiter and a three-state sequencer (IDLE -> ACCESS -> RESP).
//   A granted transaction is latched at grant. The memory strobe is driven for
//   exactly one cycle (ACCESS). One cycle later (RESP) the granted port sees a
//   one-cycle ack with registered err/rdata. Out-of-range word addresses never
//   touch memory and complete with err=1, rdata=0.
//
// Ports
//   clk                    clock, all state on rising edge
//   reset                  asynchronous active-low reset
//   pN_req/we/addr/wdata   requester N transaction (held until ack)
//   pN_ack/err/rdata       requester N completion (err/rdata qualified by ack)
//   mem_read/mem_write     memory strobes (one cycle per in-range transaction)
//   mem_addr/mem_wdata     memory address / write data
//   mem_rdata              combinational memory read data
//   busy                   1 whenever the sequencer is not IDLE
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wdata,
    output logic              p0_ack,
    output logic              p0_err,
    output logic [31:0]       p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wdata,
    output logic              p1_ack,
    output logic              p1_err,
    output logic [31:0]       p1_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t              state_q,     state_d;
    logic                last_gnt_q,  last_gnt_d;
    logic                gnt_q,       gnt_d;
    logic                err_lat_q,   err_lat_d;
    logic                mem_read_q,  mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                p0_ack_q,    p0_ack_d;
    logic                p1_ack_q,    p1_ack_d;
    logic                p0_err_q,    p0_err_d;
    logic                p1_err_q,    p1_err_d;
    logic [31:0]         p0_rdata_q,  p0_rdata_d;
    logic [31:0]         p1_rdata_q,  p1_rdata_d;
    logic                busy_q,      busy_d;

    logic                win_s;
    logic                sel_we_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [31:0]         sel_wdata_s;
    logic                in_range_s;
    logic [31:0]         cap_rdata_s;

    // Round-robin winner selection and the winner's request fields.
    always_comb begin
        win_s = 1'b0;
        if (p0_req && p1_req) begin
            // Tie: the port that did not win last time goes first.
            win_s = ~last_gnt_q;
        end else if (p1_req) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        sel_we_s    = win_s ? p1_we    : p0_we;
        sel_addr_s  = win_s ? p1_addr  : p0_addr;
        sel_wdata_s = win_s ? p1_wdata : p0_wdata;
        in_range_s  = (sel_addr_s < ADDR_W'(DEPTH));
        // Only a real read returns memory data; writes and errors return zero.
        cap_rdata_s = mem_read_q ? mem_rdata : 32'h0000_0000;
    end

    // Sequencer next-state and registered-output next values.
    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        gnt_d       = gnt_q;
        err_lat_d   = err_lat_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        p0_ack_d    = 1'b0;
        p1_ack_d    = 1'b0;
        p0_err_d    = p0_err_q;
        p1_err_d    = p1_err_q;
        p0_rdata_d  = p0_rdata_q;
        p1_rdata_d  = p1_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (p0_req || p1_req) begin
                    gnt_d       = win_s;
                    last_gnt_d  = win_s;
                    mem_addr_d  = sel_addr_s;
                    mem_wdata_d = sel_wdata_s;
                    // Strobes are registered here so they are high during ACCESS only.
                    mem_write_d = in_range_s & sel_we_s;
                    mem_read_d  = in_range_s & ~sel_we_s;
                    err_lat_d   = ~in_range_s;
                    state_d     = ST_ACCESS;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (gnt_q) begin
                    p1_rdata_d = cap_rdata_s;
                    p1_err_d   = err_lat_q;
                    p1_ack_d   = 1'b1;
                end else begin
                    p0_rdata_d = cap_rdata_s;
                    p0_err_d   = err_lat_q;
                    p0_ack_d   = 1'b1;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            last_gnt_q  <= 1'b1;
            gnt_q       <= 1'b0;
            err_lat_q   <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= 32'h0000_0000;
            p0_ack_q    <= 1'b0;
            p1_ack_q    <= 1'b0;
            p0_err_q    <= 1'b0;
            p1_err_q    <= 1'b0;
            p0_rdata_q  <= 32'h0000_0000;
            p1_rdata_q  <= 32'h0000_0000;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            gnt_q       <= gnt_d;
            err_lat_q   <= err_lat_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            p0_ack_q    <= p0_ack_d;
            p1_ack_q    <= p1_ack_d;
            p0_err_q    <= p0_err_d;
            p1_err_q    <= p1_err_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign p0_ack    = p0_ack_q;
    assign p1_ack    = p1_ack_q;
    assign p0_err    = p0_err_q;
    assign p1_err    = p1_err_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed self-checking bench for dmem_arbiter. Expected completions are
//   pushed to a scoreboard queue when a request is driven and popped by a
//   monitor whenever an ack appears. A behavioural memory sits on the memory
//   port; a separate reference array supplies expected read data.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 32;

    logic              clk;
    logic              reset;
    logic              p0_req, p0_we, p1_req, p1_we;
    logic [ADDR_W-1:0] p0_addr, p1_addr;
    logic [31:0]       p0_wdata, p1_wdata;
    logic              p0_ack, p0_err, p1_ack, p1_err;
    logic [31:0]       p0_rdata, p1_rdata;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              busy;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb_q[$];

    logic [31:0] mem     [DEPTH] = '{default: 32'h0000_0000};
    logic [31:0] ref_mem [DEPTH] = '{default: 32'h0000_0000};

    dmem_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: read data is garbage unless mem_read is high.
    assign mem_rdata = (mem_read && mem_addr < DEPTH) ? mem[mem_addr[5:0]] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (mem_write && mem_addr < DEPTH) mem[mem_addr[5:0]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every ack is matched against the oldest expectation.
    always @(negedge clk) begin
        if (reset && (p0_ack || p1_ack)) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ack", {62'd0, p1_ack, p0_ack}, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("ack_port", {62'd0, p1_ack, p0_ack}, e.port ? 64'd2 : 64'd1);
                check("ack_err", e.port ? p1_err : p0_err, e.err);
                check("ack_rdata", e.port ? p1_rdata : p0_rdata, e.rdata);
            end
        end
    end

    function automatic exp_t make_exp(input logic port, input logic we, input logic [31:0] addr,
                                      input logic [31:0] wdata);
        exp_t e;
        logic in_range;
        in_range = (addr < DEPTH);
        e.port   = port;
        e.err    = !in_range;
        e.rdata  = (!we && in_range) ? ref_mem[addr[5:0]] : 32'h0000_0000;
        if (we && in_range) ref_mem[addr[5:0]] = wdata;
        return e;
    endfunction

    task automatic drive(input logic port, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end
    endtask

    // One isolated transaction: checks latency, strobe count and strobe values.
    task automatic do_txn(input logic port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input string tag);
        int  wr_cnt = 0;
        int  rd_cnt = 0;
        int  lat    = 0;
        logic got   = 1'b0;
        logic in_range;
        in_range = (addr < DEPTH);
        @(negedge clk);
        sb_q.push_back(make_exp(port, we, addr, wdata));
        drive(port, 1'b1, we, addr, wdata);
        for (int i = 1; i <= 8 && !got; i++) begin
            @(negedge clk);
            if (mem_write) begin
                wr_cnt++;
                check({tag, "_waddr"}, mem_addr, addr);
                check({tag, "_wdata"}, mem_wdata, wdata);
            end
            if (mem_read) begin
                rd_cnt++;
                check({tag, "_raddr"}, mem_addr, addr);
            end
            if (port ? p1_ack : p0_ack) begin
                got = 1'b1;
                lat = i;
                drive(port, 1'b0, we, addr, wdata);
            end
        end
        check({tag, "_got_ack"}, got, 1'b1);
        check({tag, "_latency"}, lat, 2);
        check({tag, "_wr_strobes"}, wr_cnt, (we && in_range) ? 1 : 0);
        check({tag, "_rd_strobes"}, rd_cnt, (!we && in_range) ? 1 : 0);
        if (!got) drive(port, 1'b0, we, addr, wdata);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {57'd0, p0_ack, p1_ack, p0_err, p1_err, mem_read, mem_write, busy}, 64'd0);
        check({tag, "_rdata"}, {p0_rdata, p1_rdata}, 64'd0);
        check({tag, "_mem"}, {mem_addr, mem_wdata}, 64'd0);
    endtask

    initial begin
        int p0_t1, p1_t, p0_t2, n_ack, busy_low, rd_cnt;
        int ack_at[3];
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;

        // Single write, read back, boundary and out-of-range accesses
        do_txn(1'b0, 1'b1, 32'd5,  32'hDEAD_BEEF, "p0_wr5");
        do_txn(1'b1, 1'b0, 32'd5,  32'h0000_0000, "p1_rd5");
        do_txn(1'b1, 1'b1, 32'd63, 32'hCAFE_F00D, "p1_wr63");
        do_txn(1'b0, 1'b0, 32'd63, 32'h0000_0000, "p0_rd63");
        do_txn(1'b0, 1'b0, 32'd64, 32'h0000_0000, "p0_rd64");
        do_txn(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, "p1_wr_max");
        do_txn(1'b0, 1'b0, 32'd0,  32'h0000_0000, "p0_rd0");

        // Reset during ACCESS of a p1 write: everything drops, no ack follows
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 32'd7, 32'h0000_0077);
        @(negedge clk);
        check("midrst_access_wr", mem_write, 1'b1);
        #2 reset = 1'b0;
        #1 check_all_zero("midrst");
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (4) begin
            @(negedge clk);
            check("midrst_no_ack", {p0_ack, p1_ack}, 2'b00);
        end
        reset = 1'b1;

        // Contention right after reset: p0 first, p1 second, p0 re-request after p1
        @(negedge clk);
        sb_q.push_back(make_exp(1'b0, 1'b1, 32'd1, 32'h0000_0011));
        sb_q.push_back(make_exp(1'b1, 1'b1, 32'd2, 32'h0000_0022));
        drive(1'b0, 1'b1, 1'b1, 32'd1, 32'h0000_0011);
        drive(1'b1, 1'b1, 1'b1, 32'd2, 32'h0000_0022);
        p0_t1 = 0; p1_t = 0; p0_t2 = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (p0_ack && p0_t1 == 0) begin
                p0_t1 = i;
                drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
            end else if (p0_ack && p0_t2 == 0) begin
                p0_t2 = i;
                drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
            end else if (p0_t1 != 0 && i == p0_t1 + 1) begin
                sb_q.push_back(make_exp(1'b0, 1'b1, 32'd3, 32'h0000_0033));
                drive(1'b0, 1'b1, 1'b1, 32'd3, 32'h0000_0033);
            end
            if (p1_ack && p1_t == 0) begin
                p1_t = i;
                drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        check("tie_p0_first_ack", p0_t1, 2);
        check("tie_p1_second_ack", p1_t, 5);
        check("tie_p0_rereq_ack", p0_t2, 8);
        do_txn(1'b1, 1'b0, 32'd2, 32'h0000_0000, "p1_rd2");
        do_txn(1'b0, 1'b0, 32'd3, 32'h0000_0000, "p0_rd3");
        do_txn(1'b1, 1'b0, 32'd1, 32'h0000_0000, "p1_rd1");

        // Continuous p0 requests: acks 3 cycles apart, busy low one cycle between
        @(negedge clk);
        repeat (3) sb_q.push_back(make_exp(1'b0, 1'b0, 32'd5, 32'h0000_0000));
        drive(1'b0, 1'b1, 1'b0, 32'd5, 32'h0000_0000);
        n_ack = 0; busy_low = 0; rd_cnt = 0;
        ack_at[0] = 0; ack_at[1] = 0; ack_at[2] = 0;
        for (int i = 1; i <= 12 && n_ack < 3; i++) begin
            @(negedge clk);
            if (mem_read) rd_cnt++;
            if (n_ack >= 1 && !busy) busy_low++;
            if (p0_ack) begin
                ack_at[n_ack] = i;
                n_ack++;
                if (n_ack == 3) drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("cont_ack_count", n_ack, 3);
        check("cont_ack0", ack_at[0], 2);
        check("cont_ack1", ack_at[1], 5);
        check("cont_ack2", ack_at[2], 8);
        check("cont_busy_low", busy_low, 2);
        check("cont_rd_strobes", rd_cnt, 3);

        repeat (4) @(negedge clk);
        check("idle_busy", busy, 1'b0);
        check("sb_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
